// File: rtl/dcache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache : 8 x 4-byte direct-mapped, write-back, write-allocate data cache
// Revision 1.0
// ---------------------------------------------------------------------------
module dcache (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [7:0]  valid;
  logic [7:0]  dirty;
  logic [2:0]  tags [8];
  logic [31:0] data [8];
  logic [31:0] fetched;

  logic [2:0]  tag;
  logic [2:0]  index;
  logic [1:0]  offset;
  logic        access;
  logic        hit;
  logic        write_hit;

  assign tag       = address[7:5];
  assign index     = address[4:2];
  assign offset    = address[1:0];
  assign access    = read ^ write;
  assign hit       = valid[index] && (tags[index] == tag);
  assign write_hit = (state == IDLE) && write && !read && hit;
  assign readdata  = data[index][{offset, 3'b000} +: 8];
  // Gated by reset so the stall drops at once even while a request is held.
  assign busywait  = !reset && access && ((state != IDLE) || !hit);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (access && !hit) next_state = dirty[index] ? WRITEBACK : FETCH;
      WRITEBACK: if (!mem_busywait) next_state = FETCH;
      FETCH:     if (!mem_busywait) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'd0;
    mem_writedata = 32'd0;
    case (state)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tags[index], index};
        mem_writedata = data[index];
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = address[7:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= 8'd0;
      dirty   <= 8'd0;
      fetched <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        tags[i] <= 3'd0;
        data[i] <= 32'd0;
      end
    end else begin
      state <= next_state;
      if (state == FETCH && !mem_busywait)
        fetched <= mem_readdata;
      if (state == UPDATE) begin
        data[index]  <= fetched;
        tags[index]  <= tag;
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
      if (write_hit) begin
        data[index][{offset, 3'b000} +: 8] <= writedata;
        dirty[index] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
